post_gray_packer: RTL and testbench

- Write-side counterpart of the read-side word unpacker.
- Accepts a group of four 24-bit pixels from the pixel datapath and repacks them into three 32-bit words, MSB-first.
- Emits each word to the memory write interface through a valid/ack handshake.
- Counts completed groups and flags the last group of a frame, so the top-level controller knows when write-back is finished.

---
 rtl/post_gray_packer.sv | 105 ++++++++++
 tb/tb_post_gray_packer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/post_gray_packer.sv
// Write-side pixel packer: captures a group of four 24-bit {R,G,B} pixels and
// emits them as three 32-bit words, MSB-first, over a valid/ack handshake.
// Counts completed groups and flags the last group of each frame.
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   rst         synchronous active-high reset (priority over everything)
//   in_pixels   pixel group; [3] is first in memory order, [0] last
//   load_en     load strobe, captured only while ready=1
//   write_ack   memory writer accepted the current write_word
//   ready       idle and able to accept a group
//   write_word  packed word to memory
//   write_en    write_word valid
//   group_done  one-cycle pulse after the third word of a group is acked
//   frame_done  one-cycle pulse with group_done on the last group of a frame
module post_gray_packer #(
  parameter int unsigned FRAME_GROUPS = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0][23:0] in_pixels,
  input  logic             load_en,
  input  logic             write_ack,
  output logic             ready,
  output logic [31:0]      write_word,
  output logic             write_en,
  output logic             group_done,
  output logic             frame_done
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(FRAME_GROUPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    W0,
    W1,
    W2
  } state_t;

  state_t           state;
  logic [3:0][23:0] pix;
  logic [CNT_W-1:0] group_cnt;

  // Handshake FSM; each state holds its word until write_ack is sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pix        <= '0;
      group_cnt  <= '0;
      ready      <= 1'b1;
      write_word <= '0;
      write_en   <= 1'b0;
      group_done <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      group_done <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_en) begin
            // word0 comes straight from the input so it is visible one cycle
            // after the load edge.
            pix        <= in_pixels;
            state      <= W0;
            ready      <= 1'b0;
            write_en   <= 1'b1;
            write_word <= {in_pixels[3], in_pixels[2][23:16]};
          end
        end
        W0: begin
          if (write_ack) begin
            state      <= W1;
            write_word <= {pix[2][15:0], pix[1][23:8]};
          end
        end
        W1: begin
          if (write_ack) begin
            state      <= W2;
            write_word <= {pix[1][7:0], pix[0]};
          end
        end
        W2: begin
          if (write_ack) begin
            state      <= IDLE;
            write_en   <= 1'b0;
            ready      <= 1'b1;
            group_done <= 1'b1;
            // Wrap at the frame boundary; FRAME_GROUPS=1 flags every group.
            if (group_cnt == LAST_GROUP) begin
              frame_done <= 1'b1;
              group_cnt  <= '0;
            end else begin
              group_cnt  <= group_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_post_gray_packer.sv
// Self-checking bench for post_gray_packer. A reference model derives the
// three expected words by slicing the 96-bit pixel group into 32-bit chunks
// and tracks the frame position by counting completed groups.
module tb_post_gray_packer;

  localparam int unsigned FG = 3;

  logic             tb_clk = 1'b0;
  logic             rst;
  logic [3:0][23:0] in_pixels;
  logic             load_en;
  logic             write_ack;
  logic             ready;
  logic [31:0]      write_word;
  logic             write_en;
  logic             group_done;
  logic             frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int groups_seen = 0;

  post_gray_packer #(.FRAME_GROUPS(FG)) dut (
    .clk        (tb_clk),
    .rst        (rst),
    .in_pixels  (in_pixels),
    .load_en    (load_en),
    .write_ack  (write_ack),
    .ready      (ready),
    .write_word (write_word),
    .write_en   (write_en),
    .group_done (group_done),
    .frame_done (frame_done)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  function automatic logic [95:0] rand_group();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_write_en"}, 32'(write_en), 32'd0);
    chk({tag, "_group_done"}, 32'(group_done), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  // mode 0: ack tied high; 1: five-cycle ack stall on word1; 2: random acks.
  // busy: pulse load_en with other pixels while word1 is pending.
  task automatic run_group(input logic [95:0] grp, input int mode, input bit busy);
    logic [31:0] exp_w [3];
    logic        ack;
    int          stalls;
    bit          exp_frame;
    for (int i = 0; i < 3; i++) exp_w[i] = grp[95 - 32*i -: 32];

    chk("ready_before_load", 32'(ready), 32'd1);
    in_pixels = grp;
    load_en   = 1'b1;
    step();
    load_en   = 1'b0;
    in_pixels = rand_group();

    for (int w = 0; w < 3; w++) begin
      stalls = 0;
      do begin
        chk($sformatf("word%0d_en", w), 32'(write_en), 32'd1);
        chk($sformatf("word%0d_data", w), write_word, exp_w[w]);
        chk("ready_busy", 32'(ready), 32'd0);
        chk("group_done_busy", 32'(group_done), 32'd0);
        chk("frame_done_busy", 32'(frame_done), 32'd0);
        case (mode)
          0:       ack = 1'b1;
          1:       ack = !(w == 1 && stalls < 5);
          default: ack = (stalls >= 6) ? 1'b1 : ($urandom_range(0, 2) != 0);
        endcase
        if (busy && w == 1 && stalls == 0) begin
          load_en   = 1'b1;
          in_pixels = rand_group();
        end
        write_ack = ack;
        step();
        load_en = 1'b0;
        stalls++;
      end while (!ack);
    end

    groups_seen++;
    exp_frame = (groups_seen % FG) == 0;
    chk("group_done_pulse", 32'(group_done), 32'd1);
    chk("frame_done_pulse", 32'(frame_done), 32'(exp_frame));
    chk("ready_after_group", 32'(ready), 32'd1);
    chk("write_en_after_group", 32'(write_en), 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    rst       = 1'b1;
    load_en   = 1'b1;
    write_ack = 1'b1;
    in_pixels = rand_group();
    for (int i = 0; i < cycles; i++) step();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_write_en", 32'(write_en), 32'd0);
    chk("rst_write_word", write_word, 32'd0);
    chk("rst_group_done", 32'(group_done), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    rst         = 1'b0;
    load_en     = 1'b0;
    groups_seen = 0;
    step();
    check_idle("post_reset");
  endtask

  initial begin
    logic [95:0] basic;
    basic     = {24'hFF00AA, 24'hF01300, 24'hAA8713, 24'h00AA87};
    rst       = 1'b0;
    load_en   = 1'b0;
    write_ack = 1'b0;
    in_pixels = '0;

    do_reset(2);

    // Known-answer words for the reference group.
    chk("kat_word0", basic[95:64], 32'hFF00AAF0);
    chk("kat_word1", basic[63:32], 32'h1300AA87);
    chk("kat_word2", basic[31:0],  32'h1300AA87);

    run_group(basic, 0, 1'b0);
    step();
    check_idle("idle_gap");
    run_group(basic, 1, 1'b0);
    run_group(basic, 1, 1'b1);

    // Frame counter from a clean start: frame_done on groups 3 and 6.
    do_reset(1);
    for (int g = 0; g < 7; g++) run_group(rand_group(), 0, 1'b0);
    step();
    check_idle("after_frames");

    // Mid-group reset abandons the group in flight.
    run_group(rand_group(), 0, 1'b0);
    in_pixels = rand_group();
    load_en   = 1'b1;
    write_ack = 1'b1;
    step();
    load_en = 1'b0;
    step();
    chk("pre_rst_in_w1", 32'(write_en), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    groups_seen = 0;
    chk("midrst_write_en", 32'(write_en), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_write_word", write_word, 32'd0);
    chk("midrst_group_done", 32'(group_done), 32'd0);
    for (int g = 0; g < 3; g++) run_group(rand_group(), 0, 1'b0);

    // Random groups, random ack patterns and idle gaps.
    for (int g = 0; g < 25; g++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int i = 0; i < gap; i++) begin
        write_ack = 1'($urandom_range(0, 1));
        step();
        check_idle("rand_gap");
      end
      run_group(rand_group(), 2, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
